// File: rtl/cplx_butterfly_pipe.sv
// Three-stage complex butterfly / multiply / power pipeline with Q1.FRAC_W twiddles,
// whole-pipe stall on output backpressure, per-result saturation flag and counter.
module cplx_butterfly_pipe #(
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 31,
  parameter int SCALE_HALF = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [DATA_W-1:0] w_re,
  input  logic [DATA_W-1:0] w_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y0_re,
  output logic [DATA_W-1:0] y0_im,
  output logic [DATA_W-1:0] y1_re,
  output logic [DATA_W-1:0] y1_im,
  output logic              sat_flag,
  output logic [15:0]       sat_count
);

  localparam int PW = 2 * DATA_W;
  localparam int TW = PW + 2;
  localparam logic [1:0] OP_BFLY = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_PWR  = 2'b10;
  localparam logic signed [TW-1:0] MAXV = {{(TW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV = {{(TW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [TW-1:0] RND  = {{(TW-1){1'b0}}, 1'b1} << (FRAC_W - 1);

  function automatic logic [DATA_W:0] sat(input logic signed [TW-1:0] x);
    if (x > MAXV)      return {1'b1, MAXV[DATA_W-1:0]};
    else if (x < MINV) return {1'b1, MINV[DATA_W-1:0]};
    else               return {1'b0, x[DATA_W-1:0]};
  endfunction

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // S1: operand select and the four full-width products
  logic signed [DATA_W-1:0] m_xr, m_xi, m_yr, m_yi;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_W-1:0] a_re1, a_im1;
  logic [1:0]               op1;
  logic                     v1;

  always_comb begin
    m_xr = $signed(b_re);
    m_xi = $signed(b_im);
    m_yr = $signed(w_re);
    m_yi = $signed(w_im);
    if (op == OP_PWR) begin
      m_xr = $signed(a_re);
      m_xi = $signed(a_im);
      m_yr = $signed(a_re);
      m_yi = $signed(a_im);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; op1 <= OP_BFLY; a_re1 <= '0; a_im1 <= '0;
      p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        op1   <= (op == 2'b11) ? OP_BFLY : op;
        a_re1 <= $signed(a_re);
        a_im1 <= $signed(a_im);
        p_rr  <= PW'(m_xr) * PW'(m_yr);
        p_ii  <= PW'(m_xi) * PW'(m_yi);
        p_ri  <= PW'(m_xr) * PW'(m_yi);
        p_ir  <= PW'(m_xi) * PW'(m_yr);
      end
    end
  end

  // S2: sum and round half-up
  logic signed [TW-1:0]     s_re, s_im, t_re, t_im;
  logic signed [DATA_W-1:0] a_re2, a_im2;
  logic [1:0]               op2;
  logic                     v2;

  always_comb begin
    s_re = (op1 == OP_PWR) ? TW'(p_rr) + TW'(p_ii) : TW'(p_rr) - TW'(p_ii);
    s_im = TW'(p_ri) + TW'(p_ir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; op2 <= OP_BFLY; a_re2 <= '0; a_im2 <= '0; t_re <= '0; t_im <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        op2   <= op1;
        a_re2 <= a_re1;
        a_im2 <= a_im1;
        t_re  <= (s_re + RND) >>> FRAC_W;
        t_im  <= (s_im + RND) >>> FRAC_W;
      end
    end
  end

  // S3: butterfly add/sub, optional halving, saturation
  logic signed [TW-1:0] r0re, r0im, r1re, r1im;
  logic [DATA_W:0]      q0re, q0im, q1re, q1im;

  always_comb begin
    r0re = t_re;
    r0im = t_im;
    r1re = '0;
    r1im = '0;
    case (op2)
      OP_MUL: ;
      OP_PWR: r0im = '0;
      default: begin
        r0re = TW'(a_re2) + t_re;
        r0im = TW'(a_im2) + t_im;
        r1re = TW'(a_re2) - t_re;
        r1im = TW'(a_im2) - t_im;
        if (SCALE_HALF != 0) begin
          r0re = r0re >>> 1;
          r0im = r0im >>> 1;
          r1re = r1re >>> 1;
          r1im = r1im >>> 1;
        end
      end
    endcase
    q0re = sat(r0re);
    q0im = sat(r0im);
    q1re = sat(r1re);
    q1im = sat(r1im);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; sat_flag <= 1'b0;
      y0_re <= '0; y0_im <= '0; y1_re <= '0; y1_im <= '0;
    end else if (en) begin
      out_valid <= v2;
      sat_flag  <= v2 && (q0re[DATA_W] || q0im[DATA_W] || q1re[DATA_W] || q1im[DATA_W]);
      if (v2) begin
        y0_re <= q0re[DATA_W-1:0];
        y0_im <= q0im[DATA_W-1:0];
        y1_re <= q1re[DATA_W-1:0];
        y1_im <= q1im[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (out_valid && out_ready && sat_flag && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_cplx_butterfly_pipe.sv
// Scoreboard bench for cplx_butterfly_pipe: directed vectors with hand-computed results,
// backpressure, mid-flight reset and saturation-counter ceiling.
module tb_cplx_butterfly_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, sat_flag;
  logic [1:0]  op;
  logic [31:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic [31:0] y0_re, y0_im, y1_re, y1_im;
  logic [15:0] sat_count;

  typedef struct {
    logic [31:0] y0r, y0i, y1r, y1i;
    logic        sat;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0, stalls = 0;
  logic [15:0] mdl_cnt = 16'd0;
  bit          prev_stall = 1'b0;
  logic [31:0] h_y0r, h_y0i, h_y1r, h_y1i;
  logic        h_sat;

  cplx_butterfly_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .sat_flag(sat_flag), .sat_count(sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] y0r, y0i, y1r, y1i, input logic s);
    exp_t e;
    e.y0r = y0r; e.y0i = y0i; e.y1r = y1r; e.y1i = y1i; e.sat = s; e.acc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] ar, ai, br, bi, wr, wi,
                      input exp_t e, input bit lat);
    int n = 0;
    op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accepted");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.acc = cyc;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d_pending required=0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) chk("sat_count", {48'd0, sat_count}, {48'd0, mdl_cnt});
      if (prev_stall) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_y", {y0_re, y1_re}, {h_y0r, h_y1r});
        chk("hold_yi", {y0_im, y1_im}, {h_y0i, h_y1i});
        chk("hold_sat", {63'd0, sat_flag}, {63'd0, h_sat});
      end
      if (out_valid && !out_ready) begin
        stalls++;
        chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out actual=out_valid required=no_result y0_re=%0h", y0_re);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("y0", {y0_re, y0_im}, {e.y0r, e.y0i});
          chk("y1", {y1_re, y1_im}, {e.y1r, e.y1i});
          chk("sat_flag", {63'd0, sat_flag}, {63'd0, e.sat});
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
          if (e.sat && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
        end
      end
      prev_stall = out_valid && !out_ready;
      h_y0r = y0_re; h_y0i = y0_im; h_y1r = y1_re; h_y1i = y1_im; h_sat = sat_flag;
    end
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; op = 2'b00;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_sat_count", {48'd0, sat_count}, 64'd0);
    chk("rst_y", {y0_re, y1_im}, 64'd0);
    chk("rst_sat_flag", {63'd0, sat_flag}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors; T is rounded half-up before the add/sub.
    send(2'b00, 32'h20000000, 0, 32'h20000000, 0, 32'h7FFFFFFF, 0,
         mk(32'h40000000, 0, 32'h00000000, 0, 1'b0), 1);
    send(2'b00, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0,
         mk(32'h7FFFFFFF, 0, 32'h00000001, 0, 1'b1), 1);
    send(2'b10, 32'h40000000, 32'h40000000, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h33333333,
         mk(32'h40000000, 0, 0, 0, 1'b0), 1);
    send(2'b01, 32'h11111111, 32'h22222222, 0, 32'h40000000, 32'h40000000, 0,
         mk(0, 32'h20000000, 0, 0, 1'b0), 1);
    send(2'b11, 32'h20000000, 0, 32'h20000000, 0, 32'h7FFFFFFF, 0,
         mk(32'h40000000, 0, 32'h00000000, 0, 1'b0), 1);
    send(2'b00, 32'h80000000, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0,
         mk(32'hFFFFFFFE, 0, 32'h80000000, 0, 1'b1), 1);
    send(2'b00, 0, 0, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
         mk(0, 32'h40000000, 0, 32'hC0000000, 1'b0), 1);
    send(2'b01, 0, 0, 32'h80000000, 0, 32'h80000000, 0,
         mk(32'h7FFFFFFF, 0, 0, 0, 1'b1), 1);
    send(2'b10, 32'h80000000, 32'h80000000, 0, 0, 0, 0,
         mk(32'h7FFFFFFF, 0, 0, 0, 1'b1), 1);
    send(2'b01, 0, 0, 32'hFFFFFFFF, 0, 32'h40000000, 0, mk(0, 0, 0, 0, 1'b0), 1);
    send(2'b01, 0, 0, 32'h00000001, 0, 32'h40000000, 0, mk(1, 0, 0, 0, 1'b0), 1);
    drain();
    chk("sat_count_dir", {48'd0, sat_count}, 64'd4);

    // Backpressure: W = 0 so y0 = y1 = A for every beat.
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(2'b00, 32'(k + 1), 32'(k * 256), 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0,
               mk(32'(k + 1), 32'(k * 256), 32'(k + 1), 32'(k * 256), 1'b0), 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_seen", 64'(stalls > 0), 64'd1);

    // Mid-flight reset with two beats in the pipe.
    send(2'b00, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0,
         mk(32'h7FFFFFFF, 0, 32'h00000001, 0, 1'b1), 1);
    send(2'b00, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0,
         mk(32'h7FFFFFFF, 0, 32'h00000001, 0, 1'b1), 1);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    mdl_cnt = 16'd0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_count", {48'd0, sat_count}, 64'd0);
    chk("mid_rst_y0", {32'd0, y0_re}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
    send(2'b01, 0, 0, 32'h00000001, 0, 32'h40000000, 0, mk(1, 0, 0, 0, 1'b0), 1);
    drain();

    // Counter ceiling.
    for (int i = 0; i < 70000; i++)
      send(2'b01, 0, 0, 32'h80000000, 0, 32'h80000000, 0, mk(32'h7FFFFFFF, 0, 0, 0, 1'b1), 1);
    drain();
    chk("sat_count_cap", {48'd0, sat_count}, 64'h000000000000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
